// File: rtl/simple_pipe_pkg.sv
// Shared types, opcode constants and instruction-field helpers for the simple-pipe ISA.
// Encoding: op[7:6], rs1[5:4], rs2[3:2], rd[1:0]; the LI immediate is [5:2].
package simple_pipe_pkg;

    typedef logic [1:0] reg_idx_t;
    typedef logic [7:0] data_t;
    typedef logic [1:0] op_t;

    localparam op_t OP_NOP = 2'b00;
    localparam op_t OP_ADD = 2'b01;
    localparam op_t OP_SUB = 2'b10;
    localparam op_t OP_LI  = 2'b11;

    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 2;

    typedef struct packed {
        op_t      op;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        data_t    imm;
    } dec_t;

    function automatic dec_t decode(input data_t i);
        dec_t d;
        d.op  = i[OP_HI:OP_LO];
        d.rs1 = i[RS1_HI:RS1_LO];
        d.rs2 = i[RS2_HI:RS2_LO];
        d.rd  = i[RD_HI:RD_LO];
        d.imm = {4'b0, i[IMM_HI:IMM_LO]};
        return d;
    endfunction

endpackage

// File: rtl/simple_pipe_regfile.sv
// 4x8 architectural register file: one write port, all four entries exposed directly.
// Holds no forwarding logic; the core handles bypass.
module simple_pipe_regfile
    import simple_pipe_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           we,
    input  reg_idx_t       waddr,
    input  data_t          wdata,
    output logic [3:0][7:0] regs
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/simple_pipe_core.sv
// Two-stage simple-pipe core: ID (operand read + ALU) then WB (RF write + commit).
// The WB result is forwarded into ID so back-to-back dependent instructions never stall.
module simple_pipe_core
    import simple_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] inst,
    input  logic       inst_valid,
    output logic       inst_ready,
    input  logic       hold,
    output logic       commit_valid,
    output logic [7:0] commit_inst,
    output logic [7:0] r0,
    output logic [7:0] r1,
    output logic [7:0] r2,
    output logic [7:0] r3
);

    data_t          id_r;
    logic           id_valid;
    logic           wb_valid;
    logic           wb_we;
    reg_idx_t       wb_rd;
    data_t          wb_data;
    data_t          wb_inst;
    logic           commit_q;
    logic [3:0][7:0] rf;
    dec_t           dec;
    data_t          opa;
    data_t          opb;
    data_t          alu;

    assign inst_ready = ~hold;
    assign dec        = decode(id_r);

    // The only older in-flight writer is WB, so it is always the youngest value to forward.
    always_comb begin
        opa = rf[dec.rs1];
        opb = rf[dec.rs2];
        if (wb_valid && wb_we && (wb_rd == dec.rs1)) opa = wb_data;
        if (wb_valid && wb_we && (wb_rd == dec.rs2)) opb = wb_data;
        case (dec.op)
            OP_ADD:  alu = opa + opb;
            OP_SUB:  alu = opa - opb;
            OP_LI:   alu = dec.imm;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_r        <= '0;
            id_valid    <= 1'b0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_inst     <= '0;
            commit_q    <= 1'b0;
            commit_inst <= '0;
        end else if (!hold) begin
            if (inst_valid) begin
                id_r     <= inst;
                id_valid <= 1'b1;
            end else begin
                id_valid <= 1'b0;
            end
            wb_valid    <= id_valid;
            wb_inst     <= id_r;
            wb_rd       <= dec.rd;
            wb_we       <= id_valid && (dec.op != OP_NOP);
            wb_data     <= alu;
            commit_q    <= wb_valid;
            commit_inst <= wb_inst;
        end
    end

    // Gate the registered pulse so a commit held across a freeze is reported only once.
    assign commit_valid = commit_q & ~hold;

    simple_pipe_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wb_valid & wb_we & ~hold),
        .waddr (wb_rd),
        .wdata (wb_data),
        .regs  (rf)
    );

    assign r0 = rf[0];
    assign r1 = rf[1];
    assign r2 = rf[2];
    assign r3 = rf[3];

endmodule

// File: tb/tb_simple_pipe_core.sv
// Directed bench for simple_pipe_core: hand-computed vectors checked with immediate assertions.
module tb_simple_pipe_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] inst = 8'h00;
    logic       inst_valid = 1'b0;
    logic       inst_ready;
    logic       hold = 1'b0;
    logic       commit_valid;
    logic [7:0] commit_inst;
    logic [7:0] r0, r1, r2, r3;

    int checks = 0;
    int errors = 0;

    simple_pipe_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .hold         (hold),
        .commit_valid (commit_valid),
        .commit_inst  (commit_inst),
        .r0           (r0),
        .r1           (r1),
        .r2           (r2),
        .r3           (r3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic regs_are(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        chk({tag, "_r0"}, r0, e0);
        chk({tag, "_r1"}, r1, e1);
        chk({tag, "_r2"}, r2, e2);
        chk({tag, "_r3"}, r3, e3);
    endtask

    initial begin
        // Reset state
        #2;
        regs_are("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("rst_cv", {7'b0, commit_valid}, 8'h00);
        chk("rst_ready", {7'b0, inst_ready}, 8'h01);
        chk("rst_ci", commit_inst, 8'h00);
        tick();
        rst_n = 1'b1;

        // Back-to-back LI, ADD with bypass of r2, then SUB wrap
        inst_valid = 1'b1; inst = 8'hD5; tick();
        chk("li1_nocommit", {7'b0, commit_valid}, 8'h00);
        inst = 8'hCE; tick();
        chk("li2_nocommit", {7'b0, commit_valid}, 8'h00);
        inst = 8'h5B; tick();
        chk("c_d5_v", {7'b0, commit_valid}, 8'h01);
        chk("c_d5_i", commit_inst, 8'hD5);
        regs_are("c_d5", 8'h00, 8'h05, 8'h00, 8'h00);
        inst = 8'h84; tick();
        chk("c_ce_v", {7'b0, commit_valid}, 8'h01);
        chk("c_ce_i", commit_inst, 8'hCE);
        regs_are("c_ce", 8'h00, 8'h05, 8'h03, 8'h00);
        inst_valid = 1'b0; inst = 8'h00; tick();
        chk("c_5b_v", {7'b0, commit_valid}, 8'h01);
        chk("c_5b_i", commit_inst, 8'h5B);
        regs_are("c_5b", 8'h00, 8'h05, 8'h03, 8'h08);
        tick();
        chk("c_84_v", {7'b0, commit_valid}, 8'h01);
        chk("c_84_i", commit_inst, 8'h84);
        regs_are("c_84", 8'hFB, 8'h05, 8'h03, 8'h08);
        tick();
        chk("drain_cv", {7'b0, commit_valid}, 8'h00);

        // NOP commits without RF change; bubbles never commit
        inst_valid = 1'b1; inst = 8'h00; tick();
        inst_valid = 1'b0; tick();
        chk("nop_b1_cv", {7'b0, commit_valid}, 8'h00);
        tick();
        chk("nop_cv", {7'b0, commit_valid}, 8'h01);
        chk("nop_ci", commit_inst, 8'h00);
        regs_are("nop", 8'hFB, 8'h05, 8'h03, 8'h08);
        inst_valid = 1'b1; inst = 8'hC7; tick();
        chk("bub1_cv", {7'b0, commit_valid}, 8'h00);
        inst_valid = 1'b0; tick();
        chk("bub2_cv", {7'b0, commit_valid}, 8'h00);
        tick();
        chk("c7_cv", {7'b0, commit_valid}, 8'h01);
        chk("c7_ci", commit_inst, 8'hC7);
        regs_are("c7", 8'hFB, 8'h05, 8'h03, 8'h01);
        tick();

        // Reset mid-flight: D5 in WB, CE in ID
        inst_valid = 1'b1; inst = 8'hD5; tick();
        inst = 8'hCE; tick();
        #2;
        rst_n = 1'b0;
        #1;
        regs_are("mrst", 8'h00, 8'h00, 8'h00, 8'h00);
        chk("mrst_cv", {7'b0, commit_valid}, 8'h00);
        inst_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_after_cv", {7'b0, commit_valid}, 8'h00);
        end
        regs_are("mrst_after", 8'h00, 8'h00, 8'h00, 8'h00);

        // Hold with C7 pending commit, D5 in WB, CE in ID
        inst_valid = 1'b1; inst = 8'hC7; tick();
        inst = 8'hD5; tick();
        inst = 8'hCE; tick();
        chk("pre_hold_cv", {7'b0, commit_valid}, 8'h01);
        chk("pre_hold_ci", commit_inst, 8'hC7);
        hold = 1'b1; inst = 8'hFF;
        #1;
        chk("hold_ready", {7'b0, inst_ready}, 8'h00);
        chk("hold_cv0", {7'b0, commit_valid}, 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_cv", {7'b0, commit_valid}, 8'h00);
            regs_are("hold", 8'h00, 8'h00, 8'h00, 8'h01);
        end
        hold = 1'b0; inst_valid = 1'b0; inst = 8'h00; tick();
        chk("rel_d5_v", {7'b0, commit_valid}, 8'h01);
        chk("rel_d5_i", commit_inst, 8'hD5);
        regs_are("rel_d5", 8'h00, 8'h05, 8'h00, 8'h01);
        tick();
        chk("rel_ce_v", {7'b0, commit_valid}, 8'h01);
        chk("rel_ce_i", commit_inst, 8'hCE);
        regs_are("rel_ce", 8'h00, 8'h05, 8'h03, 8'h01);
        tick();
        chk("rel_end_cv", {7'b0, commit_valid}, 8'h00);
        tick();
        chk("rel_end2_cv", {7'b0, commit_valid}, 8'h00);
        regs_are("rel_end", 8'h00, 8'h05, 8'h03, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simple_pipe_core.md
Name: simple_pipe_core

Overview:
- Pipelined implementation of the 8-bit, four-register simple-pipe ISA.
- It consumes the same instruction word and produces the same r0..r3 architectural state that the per-instruction ILA semantic modules (NOP/ADD/SUB/LI) specify.
- Two-stage compute pipeline with a WB-to-EX bypass; a registered commit port lets the refinement checker compare the ILA next-state per committed instruction.

Parameters:
- None. All widths are fixed by the ISA: 8-bit data, 8-bit instruction, 4 registers.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  8  instruction word
- inst_valid  in  1  inst is valid this cycle
- inst_ready  out  1  core accepts inst this cycle; equals ~hold
- hold  in  1  freeze the whole pipeline
- commit_valid  out  1  one-cycle pulse per retired valid instruction
- commit_inst  out  8  instruction retired with commit_valid
- r0  out  8  architectural register 0
- r1  out  8  architectural register 1
- r2  out  8  architectural register 2
- r3  out  8  architectural register 3

Behaviour:
- Encoding:
  - op = inst[7:6], rs1 = inst[5:4], rs2 = inst[3:2], rd = inst[1:0].
  - NOP = 00: no register change.
  - ADD = 01: rd <= rs1 + rs2, mod 256.
  - SUB = 10: rd <= rs1 - rs2, mod 256, two's-complement wrap.
  - LI = 11: rd <= {4'b0, inst[5:2]}.
- Reset (async, rst_n = 0):
  - id_valid, wb_valid and commit_valid are cleared to 0.
  - commit_inst = 0; r0..r3 = 0.
  - In-flight instructions are discarded with no commit.
  - Outputs change immediately, without waiting for a clock edge.
- Accept: a handshake occurs on a rising edge with inst_valid & inst_ready. Register id_r <= inst, id_valid <= 1. If there is no handshake and hold = 0, id_valid <= 0 (bubble).
- Stage ID->WB, on a non-hold edge:
  - wb_valid <= id_valid; wb_inst <= id_r; wb_rd <= rd.
  - wb_we <= id_valid & (op != NOP).
  - wb_data <= ALU result.
- Operand read: combinational from the register file, with bypass. If wb_valid & wb_we & (wb_rd == rsN), use wb_data in place of the RF value. Bypass is evaluated independently for rs1 and rs2.
- Stage WB->RF, on a non-hold edge:
  - If wb_valid & wb_we, write wb_data to RF[wb_rd].
  - commit_valid <= wb_valid; commit_inst <= wb_inst.
- Latency: an instruction accepted at edge E0 retires at E2. From the cycle after E2, r0..r3 show the post-state and commit_valid = 1 for exactly one cycle (if hold = 0 at the next edge).
- Throughput: one instruction per cycle. There are no stalls from data hazards.
- Hold = 1:
  - No register updates anywhere, including the RF.
  - inst_ready = 0.
  - commit_valid is forced low (combinational gate on the registered pulse), so a commit is never reported twice.
  - On release, the pipeline resumes exactly where it stopped.
- A NOP that carries inst_valid is a real instruction: it commits with no RF change. Invalid slots never commit.
- Writes to the same rd in consecutive instructions: the younger overwrites; the bypass always takes the youngest in-flight value.
- r0..r3 are direct RF outputs. They never expose bypass values.

Decomposition:
- Package simple_pipe_pkg:
  - Opcode constants OP_NOP/OP_ADD/OP_SUB/OP_LI.
  - Field bit positions.
  - Register-index typedef (2 bits) and data typedef (8 bits).
- Sub-module simple_pipe_regfile: 4x8 flops with async active-low clear, one write port, and four direct read outputs. It contains no bypass logic.
- The ALU and bypass stay inline in the core.

Test Plan:
- Reset: pulse rst_n low mid-cycle -> r0..r3 = 0x00, commit_valid = 0 immediately, inst_ready = 1.
- Back-to-back LI and forwarding: issue 0xD5 (LI r1,5), 0xCE (LI r2,3), 0x5B (ADD r3 = r1 + r2) on consecutive cycles -> commits in order, r1 = 0x05, r2 = 0x03, r3 = 0x08. The ADD must bypass r2 from WB.
- SUB wrap: after the test above, issue 0x84 (SUB r0 = r0 - r1) -> r0 = 0xFB, commit_inst = 0x84.
- NOP and bubbles: valid 0x00, then two idle cycles, then 0xC7 (LI r3,1) -> exactly two commit pulses, separated by three cycles. Registers are unchanged by the NOP; then r3 = 0x01.
- Hold: with 0xD5 in WB and 0xCE in ID, raise hold for 3 cycles -> no commit, inst_ready = 0, regs frozen. After release, commits 0xD5 then 0xCE on consecutive cycles.
- Reset mid-flight: assert rst_n low while two instructions are in flight -> no commit for either after release, and all regs = 0.
